// File: rtl/pmem_loader_pkg.sv
// Shared types and constants for the byte-stream program-memory loader.
// Holds the loader FSM encoding, error codes and the default memory size.
package pmem_loader_pkg;

  // Default MSB of the program-memory word address (4K words).
  localparam int PMEM_MSB = 11;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_ADDR_LO,
    ST_ADDR_HI,
    ST_CNT_LO,
    ST_CNT_HI,
    ST_RANGE,
    ST_DATA_LO,
    ST_DATA_HI,
    ST_CHK,
    ST_DONE,
    ST_ERR
  } state_t;

  localparam logic [1:0] ERR_NONE  = 2'd0;
  localparam logic [1:0] ERR_RANGE = 2'd1;
  localparam logic [1:0] ERR_CHK   = 2'd2;

  // States in which the loader is willing to take a byte from the stream.
  function automatic logic rxState(input state_t s);
    return s inside {ST_ADDR_LO, ST_ADDR_HI, ST_CNT_LO, ST_CNT_HI,
                     ST_DATA_LO, ST_DATA_HI, ST_CHK};
  endfunction

endpackage

// File: rtl/pmem_loader_if.sv
// Byte-stream input and program-memory port B bundle for pmem_loader.
// master is the loader side, slave is the byte source / memory side.
interface pmem_loader_if
  import pmem_loader_pkg::*;
#(
  parameter int ADDR_MSB = PMEM_MSB
) ();

  logic [7:0]        rx_data;
  logic              rx_valid;
  logic              rx_ready;
  logic              enb;
  logic [1:0]        web;
  logic [ADDR_MSB:0] addrb;
  logic [15:0]       dinb;

  modport master (
    input  rx_data, rx_valid,
    output rx_ready, enb, web, addrb, dinb
  );

  modport slave (
    output rx_data, rx_valid,
    input  rx_ready, enb, web, addrb, dinb
  );

endinterface

// File: rtl/pmem_loader.sv
// Loads a framed little-endian image from a byte stream into program memory
// port B, holding the CPU in reset until a checksum-clean load completes.
module pmem_loader
  import pmem_loader_pkg::*;
#(
  parameter int ADDR_MSB = PMEM_MSB
) (
  input  logic        mclk,
  input  logic        puc_rst,
  input  logic        start,
  pmem_loader_if.master bus,
  output logic        cpu_hold,
  output logic        done,
  output logic        err,
  output logic [1:0]  err_code
);

  localparam int AW = ADDR_MSB + 1;
  localparam logic [16:0] MEM_WORDS = 17'(1) << AW;

  state_t          state_q, state_d;
  logic [15:0]     addr_q, addr_d;
  logic [15:0]     cnt_q, cnt_d;
  logic [AW-1:0]   ptr_q, ptr_d;
  logic [7:0]      lo_q, lo_d;
  logic [7:0]      sum_q, sum_d;
  logic            rx_ready_q, rx_ready_d;
  logic            enb_q, enb_d;
  logic [1:0]      web_q, web_d;
  logic [AW-1:0]   addrb_q, addrb_d;
  logic [15:0]     dinb_q, dinb_d;
  logic            cpu_hold_q, cpu_hold_d;
  logic            done_q, done_d;
  logic            err_q, err_d;
  logic [1:0]      err_code_q, err_code_d;

  logic            accept;
  logic [7:0]      sumNext;
  logic [16:0]     endAddr;
  logic            addrHigh;
  logic            rangeBad;

  assign accept   = bus.rx_valid & rx_ready_q;
  assign sumNext  = sum_q + bus.rx_data;
  // Computed at 17 bits so an image ending exactly at the top still fits.
  assign endAddr  = {1'b0, addr_q} + {1'b0, cnt_q};
  assign addrHigh = (addr_q >> AW) != 16'd0;
  assign rangeBad = addrHigh | (endAddr > MEM_WORDS);

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    cnt_d      = cnt_q;
    ptr_d      = ptr_q;
    lo_d       = lo_q;
    sum_d      = sum_q;
    enb_d      = 1'b0;
    web_d      = 2'b00;
    addrb_d    = addrb_q;
    dinb_d     = dinb_q;
    cpu_hold_d = cpu_hold_q;
    done_d     = done_q;
    err_d      = err_q;
    err_code_d = err_code_q;

    if (accept) begin
      sum_d = sumNext;
    end

    case (state_q)
      ST_IDLE, ST_DONE, ST_ERR: begin
        if (start) begin
          state_d    = ST_ADDR_LO;
          sum_d      = 8'd0;
          done_d     = 1'b0;
          err_d      = 1'b0;
          err_code_d = ERR_NONE;
          cpu_hold_d = 1'b1;
        end
      end
      ST_ADDR_LO: begin
        if (accept) begin
          addr_d[7:0] = bus.rx_data;
          state_d     = ST_ADDR_HI;
        end
      end
      ST_ADDR_HI: begin
        if (accept) begin
          addr_d[15:8] = bus.rx_data;
          state_d      = ST_CNT_LO;
        end
      end
      ST_CNT_LO: begin
        if (accept) begin
          cnt_d[7:0] = bus.rx_data;
          state_d    = ST_CNT_HI;
        end
      end
      ST_CNT_HI: begin
        if (accept) begin
          cnt_d[15:8] = bus.rx_data;
          state_d     = ST_RANGE;
        end
      end
      ST_RANGE: begin
        if (rangeBad) begin
          state_d    = ST_ERR;
          err_d      = 1'b1;
          err_code_d = ERR_RANGE;
        end else begin
          ptr_d   = addr_q[AW-1:0];
          state_d = (cnt_q == 16'd0) ? ST_CHK : ST_DATA_LO;
        end
      end
      ST_DATA_LO: begin
        if (accept) begin
          lo_d    = bus.rx_data;
          state_d = ST_DATA_HI;
        end
      end
      ST_DATA_HI: begin
        if (accept) begin
          enb_d   = 1'b1;
          web_d   = 2'b11;
          addrb_d = ptr_q;
          dinb_d  = {bus.rx_data, lo_q};
          ptr_d   = ptr_q + AW'(1);
          cnt_d   = cnt_q - 16'd1;
          state_d = (cnt_q == 16'd1) ? ST_CHK : ST_DATA_LO;
        end
      end
      ST_CHK: begin
        if (accept) begin
          if (sumNext == 8'd0) begin
            state_d    = ST_DONE;
            done_d     = 1'b1;
            cpu_hold_d = 1'b0;
          end else begin
            state_d    = ST_ERR;
            err_d      = 1'b1;
            err_code_d = ERR_CHK;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // rx_ready is registered, so it follows the state being entered.
    rx_ready_d = rxState(state_d);
  end

  always_ff @(posedge mclk) begin
    if (puc_rst) begin
      state_q    <= ST_IDLE;
      addr_q     <= 16'd0;
      cnt_q      <= 16'd0;
      ptr_q      <= '0;
      lo_q       <= 8'd0;
      sum_q      <= 8'd0;
      rx_ready_q <= 1'b0;
      enb_q      <= 1'b0;
      web_q      <= 2'b00;
      addrb_q    <= '0;
      dinb_q     <= 16'd0;
      cpu_hold_q <= 1'b1;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      err_code_q <= ERR_NONE;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      cnt_q      <= cnt_d;
      ptr_q      <= ptr_d;
      lo_q       <= lo_d;
      sum_q      <= sum_d;
      rx_ready_q <= rx_ready_d;
      enb_q      <= enb_d;
      web_q      <= web_d;
      addrb_q    <= addrb_d;
      dinb_q     <= dinb_d;
      cpu_hold_q <= cpu_hold_d;
      done_q     <= done_d;
      err_q      <= err_d;
      err_code_q <= err_code_d;
    end
  end

  assign bus.rx_ready = rx_ready_q;
  assign bus.enb      = enb_q;
  assign bus.web      = web_q;
  assign bus.addrb    = addrb_q;
  assign bus.dinb     = dinb_q;
  assign cpu_hold     = cpu_hold_q;
  assign done         = done_q;
  assign err          = err_q;
  assign err_code     = err_code_q;

endmodule
